// File: rtl/badhri_uart_rx.sv
// 8N1 UART receiver with 2-flop input synchroniser, mid-bit sampling and a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to receive 8E1 frames (even parity bit between data and stop).
module badhri_uart_rx #(
    parameter int CLKS_PER_BIT = 1042,
    parameter int CNT_W        = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    state_t           state;
    state_t           next_state;
    logic             sync_1;
    logic             rx_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             par_err;
    logic             par_mismatch;
    logic             bit_done;
    logic             cnt_clr;
    logic             shift_en;
    logic             stop_sample;
    logic             deliver;
    logic             ferr_set;

    assign bit_done = (cnt == BIT_LAST);

    // Both flops reset high so the idle line never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_1 <= rx;
            rx_s   <= sync_1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!rx_s) next_state = START;
            START:   if (cnt == HALF_LAST) next_state = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:    if (bit_done && bit_idx == 3'd7) next_state = PARITY;
            PARITY:  if (bit_done) next_state = STOP;
`else
            DATA:    if (bit_done && bit_idx == 3'd7) next_state = STOP;
`endif
            STOP:    if (bit_done) next_state = rx_s ? IDLE : BREAK;
            BREAK:   if (rx_s) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A parity failure already produced the frame_err pulse, so the stop sample stays silent.
    always_comb begin
        busy         = (state != IDLE);
        cnt_clr      = (next_state != state) || bit_done || (state == IDLE) || (state == BREAK);
        shift_en     = (state == DATA) && bit_done;
        stop_sample  = (state == STOP) && bit_done;
`ifdef UART_RX_PARITY_EN
        par_mismatch = (state == PARITY) && bit_done && (rx_s != ^shift_reg);
`else
        par_mismatch = 1'b0;
`endif
        deliver      = stop_sample && rx_s && !par_err;
        ferr_set     = (stop_sample && !rx_s && !par_err) || par_mismatch;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + 1'b1;
            if (state == START) bit_idx <= 3'd0;
            else if (shift_en)  bit_idx <= bit_idx + 3'd1;
            if (shift_en) shift_reg <= {rx_s, shift_reg[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 par_err <= 1'b0;
        else if (state == START) par_err <= 1'b0;
        else if (par_mismatch)   par_err <= 1'b1;
    end
`else
    assign par_err = 1'b0;
`endif

    // A consumer taking the old byte on the delivery cycle frees the slot for the new one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_set;
            overrun   <= 1'b0;
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift_reg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_badhri_uart_rx.sv
// Self-checking bench for badhri_uart_rx at 16 clocks per bit; expected bytes flow through a scoreboard queue.
module tb_badhri_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 2 + CPB / 2 + 10 * CPB + 1;
`else
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int         compared = 0;
    int         mismatched = 0;
    int         cycle_count = 0;
    int         deliveries = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;
    int         last_deliver_cycle = 0;
    int         t_fall;
    logic       v_before;
    logic       r_before;
    logic [7:0] exp_q[$];
    logic [7:0] pat;
`ifdef UART_RX_PARITY_EN
    logic       par_flip = 1'b0;
`endif

    badhri_uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_count <= cycle_count + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one frame starting at the current negedge and returns at the negedge ending the stop bit.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        repeat (CPB) @(negedge clk);
`endif
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            v_before <= 1'b0;
            r_before <= 1'b0;
        end else begin
            v_before <= rx_valid;
            r_before <= rx_ready;
        end
    end

    // A delivery is a valid byte that was either absent or consumed at the previous edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (rx_valid && (!v_before || r_before)) begin
                deliveries++;
                last_deliver_cycle = cycle_count;
                checkOutput("delivery_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
                if (exp_q.size() != 0) checkOutput("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_rx_data", {24'd0, rx_data}, 32'h00);
        checkOutput("reset_rx_valid", rx_valid, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_frame_err", frame_err, 1'b0);
        checkOutput("reset_overrun", overrun, 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] reset during frame 0x5A");
        pat = 8'h5A;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = pat[i];
            repeat (CPB) @(negedge clk);
        end
        rst = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        checkOutput("midreset_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("midreset_valid", rx_valid, 1'b0);
        checkOutput("midreset_deliveries", deliveries, 0);
        checkOutput("midreset_ferr", ferr_cnt, 0);
        checkOutput("midreset_ovr", ovr_cnt, 0);

        exp_q.push_back(8'hA5);
        applyStimulus(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        checkOutput("a5_valid", rx_valid, 1'b1);
        checkOutput("a5_data", {24'd0, rx_data}, 32'hA5);
        rx_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("a5_consumed", rx_valid, 1'b0);

        $display("[TB] back-to-back 0x55 0x00 0xFF");
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        t_fall = cycle_count;
        applyStimulus(8'h55, 1'b1);
        checkOutput("latency", last_deliver_cycle - t_fall, LAT);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("b2b_deliveries", deliveries, 4);
        checkOutput("b2b_queue", exp_q.size(), 0);
        checkOutput("b2b_ferr", ferr_cnt, 0);
        checkOutput("b2b_ovr", ovr_cnt, 0);

        $display("[TB] start-bit glitch");
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("glitch_busy_high", busy, 1'b1);
        repeat (20) @(negedge clk);
        checkOutput("glitch_busy_low", busy, 1'b0);
        checkOutput("glitch_deliveries", deliveries, 4);
        checkOutput("glitch_ferr", ferr_cnt, 0);

        $display("[TB] framing error and break");
        applyStimulus(8'h3C, 1'b0);
        repeat (100) @(negedge clk);
        checkOutput("break_busy", busy, 1'b1);
        checkOutput("break_ferr", ferr_cnt, 1);
        checkOutput("break_deliveries", deliveries, 4);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("break_exit_busy", busy, 1'b0);
        exp_q.push_back(8'h81);
        applyStimulus(8'h81, 1'b1);
        repeat (4) @(negedge clk);
        checkOutput("after_break_deliveries", deliveries, 5);
        checkOutput("after_break_data", {24'd0, rx_data}, 32'h81);
        checkOutput("after_break_ferr", ferr_cnt, 1);

        $display("[TB] overrun");
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        checkOutput("ovr_count", ovr_cnt, 1);
        checkOutput("ovr_valid", rx_valid, 1'b1);
        checkOutput("ovr_data_kept", {24'd0, rx_data}, 32'h11);
        checkOutput("ovr_deliveries", deliveries, 6);
        exp_q.push_back(8'h33);
        fork
            applyStimulus(8'h33, 1'b1);
            begin
                repeat (LAT - 1) @(negedge clk);
                rx_ready = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        checkOutput("swap_deliveries", deliveries, 7);
        checkOutput("swap_ovr", ovr_cnt, 1);
        checkOutput("swap_data", {24'd0, rx_data}, 32'h33);
        checkOutput("swap_valid_drained", rx_valid, 1'b0);

`ifdef UART_RX_PARITY_EN
        $display("[TB] parity");
        par_flip = 1'b0;
        exp_q.push_back(8'h07);
        applyStimulus(8'h07, 1'b1);
        repeat (4) @(negedge clk);
        checkOutput("parity_ok_deliveries", deliveries, 8);
        checkOutput("parity_ok_data", {24'd0, rx_data}, 32'h07);
        par_flip = 1'b1;
        applyStimulus(8'h07, 1'b1);
        repeat (4) @(negedge clk);
        par_flip = 1'b0;
        checkOutput("parity_bad_ferr", ferr_cnt, 2);
        checkOutput("parity_bad_deliveries", deliveries, 8);
`endif

        checkOutput("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/badhri_uart_rx.md
Name: badhri_uart_rx

Overview:
- 8N1 UART receiver. It is the receive-side counterpart of the team's UART transmit path in tt_um_badhri_uart.
- Synchronises the asynchronous serial line, detects and validates the start bit, and samples each bit at mid-bit.
- Delivers each received byte through a one-entry holding register with a valid/ready handshake.
- Sits between the ui_in serial pin and the user logic inside the Tiny Tapeout wrapper.

Parameters:
- CLKS_PER_BIT, 1042, clock cycles per bit period (10 MHz / 9600 baud). Legal values ≥ 4.
- CNT_W, 11, width of the bit-period counter. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- rx  input  1  serial line. Asynchronous to clk. Idle level is high.
- rx_data  output  8  received byte, valid while rx_valid=1.
- rx_valid  output  1  holding register occupied.
- rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready at a rising edge.
- frame_err  output  1  one-cycle pulse: stop bit (or parity, with the option) sampled bad.
- overrun  output  1  one-cycle pulse: byte completed while the holding register was full.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - Both synchroniser flops are set to 1.
  - State is IDLE and the counter is 0.
  - rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0.
- Reset asserted mid-frame aborts the frame immediately. No byte is delivered and no error pulse is generated.
- Synchroniser: 2-flop. rx_s is the second flop output. All decisions use rx_s, so there are 2 cycles of input latency.
- IDLE:
  - rx_s=0 → START, counter cleared.
- START:
  - Counts to CLKS_PER_BIT/2−1 (integer division).
  - rx_s still 0 → DATA, counter cleared, bit index 0.
  - rx_s=1 → glitch; return to IDLE with no flags.
- DATA:
  - Each bit waits CLKS_PER_BIT cycles (counter 0..CLKS_PER_BIT−1), then samples rx_s.
  - Shift register is filled LSB first.
  - After bit index 7 → STOP (or PARITY when the option is enabled).
- STOP:
  - Waits CLKS_PER_BIT cycles, then samples rx_s.
  - Sample 1 → deliver the byte (see below), then → IDLE. The next start bit can therefore be detected from the middle of the stop bit.
  - Sample 0 → frame_err pulses for 1 cycle, byte discarded, → BREAK.
- BREAK:
  - Remains until rx_s=1, then → IDLE.
  - Prevents a held-low line from being decoded as 0x00 frames.
- Delivery, on the cycle after the stop sample:
  - rx_valid=0, or rx_valid && rx_ready in the same cycle: rx_data ← shift register, rx_valid=1.
  - rx_valid=1 and rx_ready=0: overrun pulses for 1 cycle, new byte dropped, old byte and rx_valid unchanged.
- Handshake:
  - rx_valid && rx_ready with no delivery that cycle → rx_valid=0 next cycle.
  - rx_data holds its last value after consumption.
- Latency: rx_valid rises 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 cycles after the rx falling edge (+CLKS_PER_BIT with parity).
- Counter arithmetic: unsigned CNT_W bits. It is compared against CLKS_PER_BIT−1 and never wraps.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: frame is 8E1.
  - PARITY state samples the 9th bit after CLKS_PER_BIT cycles.
  - Mismatch against even parity of the data bits → frame_err pulses, byte discarded, and the stop bit is still waited for.
  - Stop = 0 after a parity error → BREAK, producing a single frame_err pulse total.
- Undefined: PARITY state is absent and the frame is 8N1 as above.

Test Plan (CLKS_PER_BIT=16):
- Reset values: assert rst mid-byte (0x5A) → no rx_valid or error pulse. Then 0xA5 after release → rx_data=0xA5, rx_valid=1.
- Basic receive: rx_ready=1, send 0x55, then 0x00, then 0xFF back to back → three rx_valid cycles with data 0x55, 0x00, 0xFF. No errors. rx_valid rises 2+8+144+1 = 155 cycles after the first falling edge.
- Glitch: rx low for 5 cycles then high → busy returns to 0, no rx_valid, no frame_err.
- Framing and break: send 0x3C with stop=0, then hold rx low 100 cycles → one frame_err pulse, no rx_valid. busy stays high until rx returns high. A following 0x81 is received correctly.
- Overrun: rx_ready=0, send 0x11 then 0x22 → rx_data=0x11, rx_valid=1, one overrun pulse. Raise rx_ready during the cycle the next byte is delivered → new byte loaded with no overrun.
- Parity (UART_RX_PARITY_EN): send 0x07 with parity bit 1 → rx_data=0x07. Send 0x07 with parity bit 0 → one frame_err pulse, no rx_valid.
